// File: rtl/usrt_tx.sv
// Synchronous serial transmitter. Sends one byte as START, 8 data bits
// (LSB first), an optional parity bit and STOP, with each bit held for a
// selectable number of clock cycles. It also drives a transmit clock that
// rises at the middle of each bit. Every output comes straight from a flop.
`timescale 1ns/1ps
module usrt_tx #(
  parameter int c_BASE_DIV = 16
) (
  input  logic       i_Pclk,
  input  logic       i_Reset_n,
  input  logic       i_Load,
  input  logic [7:0] i_Data,
  input  logic [2:0] i_Baud_Sel,
  input  logic       i_Parity_En,
  input  logic       i_Parity_Odd,
  output logic       o_Tx,
  output logic       o_Sclk,
  output logic       o_Busy,
  output logic       o_Done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;          // cycle index within the current bit
  logic [2:0]  idx_q, idx_d;          // data bit index
  logic [7:0]  shreg_q, shreg_d;      // remaining data bits, LSB goes out next
  logic [2:0]  sel_q, sel_d;          // rate select latched at load
  logic        par_en_q, par_en_d;
  logic        par_bit_q, par_bit_d;  // parity value, computed once at load
  logic        tx_d, sclk_d, busy_d, done_d;
  logic        bit_end, accept;

  // Last counter value of a bit period: (c_BASE_DIV << sel) - 1. This fits
  // in 11 bits even though the period itself (up to 2048) does not.
  function automatic logic [10:0] last_cnt(input logic [2:0] sel);
    logic [11:0] period;
    period = 12'(c_BASE_DIV) << sel;
    return 11'(period - 12'd1);
  endfunction

  assign bit_end = (cnt_q == last_cnt(sel_q));
  // A load is taken in IDLE and also in the final STOP cycle, when o_Done is
  // high. The second case lets back-to-back frames run with no gap.
  assign accept  = i_Load && ((state_q == IDLE) || (state_q == STOP && bit_end));

  // State and datapath registers, and the registered outputs
  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      sel_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      o_Tx      <= 1'b1;
      o_Sclk    <= 1'b1;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      sel_q     <= sel_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      o_Tx      <= tx_d;
      o_Sclk    <= sclk_d;
      o_Busy    <= busy_d;
      o_Done    <= done_d;
    end
  end

  // Next-state logic: frame sequencing, bit counter and shift register
  always_comb begin
    // NOTE: hold every value by default so that no path leaves a variable
    // unassigned. An unassigned path would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    sel_d     = sel_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (accept) begin
      state_d   = START;
      cnt_d     = '0;
      idx_d     = '0;
      shreg_d   = i_Data;
      sel_d     = i_Baud_Sel;
      par_en_d  = i_Parity_En;
      par_bit_d = (^i_Data) ^ i_Parity_Odd;
    end else if (state_q != IDLE) begin
      if (bit_end) begin
        cnt_d = '0;
        unique case (state_q)
          START:  state_d = DATA;
          DATA: begin
            idx_d   = 3'(idx_q + 3'd1);
            shreg_d = shreg_q >> 1;
            if (idx_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
          end
          PARITY: state_d = STOP;
          STOP:   state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end else begin
        cnt_d = 11'(cnt_q + 11'd1);
      end
    end
  end

  // Output logic: the values the outputs take after the coming edge
  always_comb begin
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    // P is even, so cnt > (P-1)/2 is exactly the second half of the bit
    sclk_d = (state_d == IDLE) || (cnt_d > (last_cnt(sel_d) >> 1));
    done_d = (state_d == STOP) && (cnt_d == last_cnt(sel_d));
  end

endmodule

// File: tb/tb_usrt_tx.sv
// Bench for usrt_tx. A frame-level model predicts every output cycle by
// cycle from the frame offset. Directed frames pin the model with literal
// bit patterns, busy lengths and done counts.
`timescale 1ns/1ps
module tb_usrt_tx;

  localparam int BASE = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data = '0;
  logic [2:0] sel = '0;
  logic       pen = 1'b0;
  logic       podd = 1'b0;
  logic       tx, sclk, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  usrt_tx #(.c_BASE_DIV(BASE)) dut (
    .i_Pclk      (clk),
    .i_Reset_n   (rst_n),
    .i_Load      (load),
    .i_Data      (data),
    .i_Baud_Sel  (sel),
    .i_Parity_En (pen),
    .i_Parity_Odd(podd),
    .o_Tx        (tx),
    .o_Sclk      (sclk),
    .o_Busy      (busy),
    .o_Done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: m_t is the cycle offset inside the current frame.
  // m_bits[i] is the value of frame bit i.
  logic        m_active = 1'b0;
  int          m_t = 0, m_p = 1, m_len = 1;
  logic [10:0] m_bits = '1;
  int          nb_tmp;
  logic [10:0] b_tmp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
    end else if (load && (!m_active || m_t == m_len - 1)) begin
      nb_tmp   = pen ? 11 : 10;
      b_tmp    = '1;
      b_tmp[0] = 1'b0;
      b_tmp[8:1] = data;
      if (pen) b_tmp[9] = (^data) ^ podd;
      m_active <= 1'b1;
      m_t      <= 0;
      m_p      <= BASE << sel;
      m_len    <= nb_tmp * (BASE << sel);
      m_bits   <= b_tmp;
    end else if (m_active) begin
      if (m_t == m_len - 1) m_active <= 1'b0;
      else m_t <= m_t + 1;
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      if (m_active) begin
        check("cyc_tx",   tx,   m_bits[m_t / m_p]);
        check("cyc_sclk", sclk, (m_t % m_p) >= (m_p / 2));
        check("cyc_busy", busy, 1'b1);
        check("cyc_done", done, m_t == m_len - 1);
      end else begin
        check("cyc_tx",   tx,   1'b1);
        check("cyc_sclk", sclk, 1'b1);
        check("cyc_busy", busy, 1'b0);
        check("cyc_done", done, 1'b0);
      end
    end
  end

  // Called at a negedge. Loads one frame, then scrambles the config inputs
  // so that any mid-frame dependence on them shows up.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic pe, input logic po);
    load = 1'b1; data = d; sel = s; pen = pe; podd = po;
    @(negedge clk);
    load = 1'b0; data = ~d; sel = s ^ 3'd3; pen = ~pe; podd = ~po;
  endtask

  // Called at the first negedge of a frame. Samples tx at mid-bit and counts
  // busy and done cycles. Optionally pulses a stray load at offset inj_t.
  // Bit 10 of exp_bits is 1 for 10-bit frames (unused position).
  task automatic measure(input string name, input logic [10:0] exp_bits, input int p,
                         input int exp_busy, input int inj_t, input logic [7:0] inj_d);
    int          t = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic [10:0] got = '1;
    while (busy === 1'b1 && t < 20000) begin
      if (t == inj_t) begin
        load = 1'b1; data = inj_d;
      end else begin
        load = 1'b0;
      end
      if (t % p == p / 2) got[t / p] = tx;
      busy_cnt++;
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
      t++;
    end
    load = 1'b0;
    check({name, "_bits"}, got, exp_bits);
    check({name, "_busy_len"}, busy_cnt, exp_busy);
    check({name, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    int dn;
    int lows;
    int k;

    // Reset state, then 100 idle cycles
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_sclk", sclk, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    dn = 0;
    repeat (100) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    check("idle_tx", tx, 1'b1);
    check("idle_sclk", sclk, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_done_cnt", dn, 0);

    // A5, sel 0, no parity: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 3'd0, 1'b0, 1'b0);
    measure("a5", 11'b11_1010_0101_0, 16, 160, -1, 8'h00);

    // 07, sel 5: even parity bit 1, then odd parity bit 0; 11*512 cycles
    send(8'h07, 3'd5, 1'b1, 1'b0);
    measure("07_even", {1'b1, 1'b1, 8'h07, 1'b0}, 512, 5632, -1, 8'h00);
    send(8'h07, 3'd5, 1'b1, 1'b1);
    measure("07_odd", {1'b1, 1'b0, 8'h07, 1'b0}, 512, 5632, -1, 8'h00);

    // Stray load of FF mid-frame is ignored
    send(8'h5C, 3'd1, 1'b0, 1'b0);
    measure("ign_ff", {2'b11, 8'h5C, 1'b0}, 32, 320, 100, 8'hFF);

    // Back-to-back: a load on the done cycle starts 3C with busy held high
    send(8'h5A, 3'd0, 1'b1, 1'b1);
    lows = 0;
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      if (busy !== 1'b1) lows++;
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", done, 1'b1);
    check("b2b_done_at", k, 175);
    load = 1'b1; data = 8'h3C; sel = 3'd0; pen = 1'b0; podd = 1'b0;
    @(negedge clk);
    load = 1'b0;
    check("b2b_busy_gap", lows, 0);
    check("b2b_busy", busy, 1'b1);
    check("b2b_start_tx", tx, 1'b0);
    measure("b2b_3c", {2'b11, 8'h3C, 1'b0}, 16, 160, -1, 8'h00);

    // Reset during data bit 4 (frame bit 5, offset 83), then a clean frame
    send(8'hC3, 3'd0, 1'b0, 1'b0);
    repeat (83) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", tx, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_sclk", sclk, 1'b1);
    check("arst_done", done, 1'b0);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    check("arst_no_done", dn, 0);
    rst_n = 1'b1;
    send(8'h81, 3'd2, 1'b1, 1'b0);
    measure("post_rst_81", {1'b1, 1'b0, 8'h81, 1'b0}, 64, 704, -1, 8'h00);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
